// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Sequences one operation at a time through an external combinational ALU.
//   A request is accepted in IDLE, the operands and one-hot select are held
//   steady while the ALU settles (one cycle, or MULDIV_WAIT extra cycles for
//   MUL/DIV), and the ALU outputs are then captured into the result registers.
//
// Ports
//   clock, clear          rising-edge clock, synchronous active-high reset
//   op_valid/op_ready     request handshake (ready only while idle)
//   op_code, op_a, op_b   operation select (0..12) and operands
//   alu_instruc           one-hot ALU select, zero while idle
//   alu_a, alu_b          latched operands presented to the ALU
//   alu_result(_hi)       ALU low/high result, alu_carry adder carry-out
//   z_lo, z_hi, z_carry   captured results
//   done                  one-cycle completion pulse
//   illegal               one-cycle pulse for rejected op_code 13..15
//   div_zero              one-cycle pulse, DIV by zero (coincides with done)
module alu_sequencer #(
    parameter int WIDTH       = 32,
    parameter int MULDIV_WAIT = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [12:0]      alu_instruc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_result_hi,
    input  logic             alu_carry,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic             z_carry,
    output logic             done,
    output logic             illegal,
    output logic             div_zero
);

    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd4;
    localparam logic [3:0] OP_DIV  = 4'd5;
    localparam logic [3:0] OP_LAST = 4'd12;
    localparam logic [3:0] WAIT_INIT = 4'(MULDIV_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT,
        S_CAPT
    } state_t;

    state_t     state;
    logic [3:0] op_q;
    logic [3:0] cnt;
    logic       is_muldiv;
    logic       div_by_zero;

    assign op_ready    = (state == S_IDLE);
    assign is_muldiv   = (op_q == OP_MUL) || (op_q == OP_DIV);
    // Divisor is checked on the latched operand, so later op_b changes are irrelevant.
    assign div_by_zero = (op_q == OP_DIV) && (alu_b == '0);

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= S_IDLE;
            op_q        <= '0;
            cnt         <= '0;
            alu_instruc <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            z_lo        <= '0;
            z_hi        <= '0;
            z_carry     <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            div_zero    <= 1'b0;
        end else begin
            done     <= 1'b0;
            illegal  <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        if (op_code <= OP_LAST) begin
                            op_q        <= op_code;
                            alu_a       <= op_a;
                            alu_b       <= op_b;
                            alu_instruc <= 13'd1 << op_code;
                            state       <= S_EXEC;
                        end else begin
                            // Rejected without touching operands or results.
                            illegal <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_muldiv && !div_by_zero) begin
                        cnt   <= WAIT_INIT;
                        state <= S_WAIT;
                    end else begin
                        state <= S_CAPT;
                    end
                end
                S_WAIT: begin
                    // Counter starts at MULDIV_WAIT, so the exit at 1 gives exactly
                    // MULDIV_WAIT cycles in this state.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    state       <= S_IDLE;
                    alu_instruc <= '0;
                    done        <= 1'b1;
                    if (div_by_zero) begin
                        z_lo     <= '1;
                        z_hi     <= alu_a;
                        z_carry  <= 1'b0;
                        div_zero <= 1'b1;
                    end else begin
                        z_lo <= alu_result;
                        if (is_muldiv) begin
                            z_hi <= alu_result_hi;
                        end
                        z_carry <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu_carry : 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU attached to the ALU port,
// expected results queued at issue time and compared when done pulses.
module tb_alu_sequencer;

    localparam int W  = 32;
    localparam int MW = 4;

    logic          clock;
    logic          clear;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [W-1:0]  op_a, op_b;
    logic [12:0]   alu_instruc;
    logic [W-1:0]  alu_a, alu_b;
    logic [W-1:0]  alu_result, alu_result_hi;
    logic          alu_carry;
    logic [W-1:0]  z_lo, z_hi;
    logic          z_carry;
    logic          done, illegal, div_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         carry;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] exp_hi = '0;

    alu_sequencer #(.WIDTH(W), .MULDIV_WAIT(MW)) dut (
        .clock(clock), .clear(clear), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .alu_instruc(alu_instruc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_result_hi(alu_result_hi), .alu_carry(alu_carry), .z_lo(z_lo),
        .z_hi(z_hi), .z_carry(z_carry), .done(done), .illegal(illegal),
        .div_zero(div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External ALU. High result and carry carry junk for ops that should not
    // capture them, so leakage into z_hi/z_carry is visible.
    logic [63:0] prod;
    logic [32:0] wide;
    always_comb begin
        alu_result    = '0;
        alu_result_hi = 32'hDEAD_BEEF;
        alu_carry     = 1'b1;
        prod          = 64'(alu_a) * 64'(alu_b);
        wide          = '0;
        case (alu_instruc)
            13'h0001: alu_result = alu_a & alu_b;
            13'h0002: alu_result = alu_a | alu_b;
            13'h0004: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = wide[31:0]; alu_carry = wide[32]; end
            13'h0008: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_result = wide[31:0]; alu_carry = wide[32]; end
            13'h0010: begin alu_result = prod[31:0]; alu_result_hi = prod[63:32]; end
            13'h0020: begin
                if (alu_b != 0) begin alu_result = alu_a / alu_b; alu_result_hi = alu_a % alu_b; end
                else begin alu_result = 32'h1234_5678; alu_result_hi = 32'h8765_4321; end
            end
            13'h0040: alu_result = alu_a >> alu_b[4:0];
            13'h0080: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            13'h0100: alu_result = alu_a << alu_b[4:0];
            13'h0200: alu_result = (alu_a >> alu_b[4:0]) | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}));
            13'h0400: alu_result = (alu_a << alu_b[4:0]) | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}));
            13'h0800: alu_result = -alu_a;
            13'h1000: alu_result = ~alu_a;
            default:  alu_result = '0;
        endcase
    end

    // Expected capture for an accepted legal operation; updates the z_hi tracker.
    function automatic exp_t expect_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [32:0] s;
        logic [4:0]  sh;
        sh      = b[4:0];
        e.hi    = exp_hi;
        e.carry = 1'b0;
        e.dz    = 1'b0;
        e.lo    = '0;
        case (code)
            4'd0:  e.lo = a & b;
            4'd1:  e.lo = a | b;
            4'd2:  begin s = {1'b0, a} + {1'b0, b}; e.lo = s[31:0]; e.carry = s[32]; end
            4'd3:  begin s = {1'b0, a} - {1'b0, b}; e.lo = s[31:0]; e.carry = s[32]; end
            4'd4:  begin p = 64'(a) * 64'(b); e.lo = p[31:0]; e.hi = p[63:32]; end
            4'd5:  begin
                if (b == 0) begin e.lo = '1; e.hi = a; e.dz = 1'b1; end
                else begin e.lo = a / b; e.hi = a % b; end
            end
            4'd6:  e.lo = a >> sh;
            4'd7:  e.lo = $unsigned($signed(a) >>> sh);
            4'd8:  e.lo = a << sh;
            4'd9:  e.lo = (sh == 0) ? a : ((a >> sh) | (a << (32 - int'(sh))));
            4'd10: e.lo = (sh == 0) ? a : ((a << sh) | (a >> (32 - int'(sh))));
            4'd11: e.lo = 32'd0 - a;
            4'd12: e.lo = ~a;
            default: e.lo = '0;
        endcase
        exp_hi = e.hi;
        return e;
    endfunction

    // Scoreboard consumer: every done pulse pops and compares one expectation.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done z_lo=%h (no operation outstanding)", z_lo);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (z_lo !== e.lo || z_hi !== e.hi || z_carry !== e.carry || div_zero !== e.dz) begin
                    errors++;
                    $display("FAIL result lo=%h hi=%h c=%b dz=%b required lo=%h hi=%h c=%b dz=%b",
                             z_lo, z_hi, z_carry, div_zero, e.lo, e.hi, e.carry, e.dz);
                end
            end
        end else if (div_zero === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL div_zero_without_done div_zero=%b required 0", div_zero);
        end
    end

    // Issue one op with op_valid for a single cycle, then scramble the inputs
    // while busy and verify held outputs and latency.
    task automatic do_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        int          lat, cyc;
        logic [12:0] oh;
        lat = (code == 4'd4 || (code == 4'd5 && b != 0)) ? 3 + MW : 3;
        oh  = 13'd1 << code;
        @(negedge clock);
        sb.push_back(expect_op(code, a, b));
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        @(negedge clock);
        op_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_code = 4'($urandom_range(0, 12));
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            checks++;
            if (alu_instruc !== oh || alu_a !== a || alu_b !== b || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL busy_outputs code=%0d cyc=%0d instruc=%h a=%h b=%h ready=%b required %h %h %h 0",
                         code, cyc, alu_instruc, alu_a, alu_b, op_ready, oh, a, b);
            end
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("FAIL latency code=%0d got %0d required %0d", code, cyc, lat);
        end
        checks++;
        if (alu_instruc !== 13'd0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle code=%0d instruc=%h ready=%b required 0 1", code, alu_instruc, op_ready);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1; op_valid = 1'b0; op_code = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clock);
        clear = 1'b0;
        checks++;
        if (op_ready !== 1'b1 || alu_instruc !== 0 || alu_a !== 0 || alu_b !== 0 || z_lo !== 0 ||
            z_hi !== 0 || z_carry !== 0 || done !== 0 || illegal !== 0 || div_zero !== 0) begin
            errors++;
            $display("FAIL reset ready=%b instruc=%h a=%h b=%h lo=%h hi=%h c=%b d=%b il=%b dz=%b required 1 and all zero",
                     op_ready, alu_instruc, alu_a, alu_b, z_lo, z_hi, z_carry, done, illegal, div_zero);
        end
        exp_hi = '0;
    endtask

    task automatic test_add();
        do_op(4'd2, 32'hFFFF_FFFF, 32'd1);
        do_op(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    endtask

    task automatic test_mul();
        do_op(4'd4, 32'h0001_0000, 32'h0001_0000);
    endtask

    task automatic test_div_zero();
        do_op(4'd5, 32'd7, 32'd0);
    endtask

    task automatic test_illegal(input logic [3:0] code);
        logic [W-1:0] lo0, hi0;
        logic         c0;
        @(negedge clock);
        lo0 = z_lo; hi0 = z_hi; c0 = z_carry;
        op_valid = 1'b1; op_code = code; op_a = $urandom; op_b = $urandom;
        @(negedge clock);
        op_valid = 1'b0;
        checks++;
        if (illegal !== 1'b1 || op_ready !== 1'b1 || alu_instruc !== 0 || z_lo !== lo0 || z_hi !== hi0 || z_carry !== c0) begin
            errors++;
            $display("FAIL illegal code=%0d il=%b ready=%b instruc=%h lo=%h hi=%h c=%b required 1 1 0 %h %h %b",
                     code, illegal, op_ready, alu_instruc, z_lo, z_hi, z_carry, lo0, hi0, c0);
        end
        @(negedge clock);
        checks++;
        if (illegal !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse code=%0d il=%b done=%b required 0 0", code, illegal, done);
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic test_ops();
        for (int c = 0; c <= 12; c++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            if (c == 5) b = (b >> 8) | 32'd1;
            do_op(4'(c), a, b);
        end
        do_op(4'd3, 32'd5, 32'd9);
        do_op(4'd7, 32'h8000_0010, 32'd4);
        do_op(4'd5, 32'd100, 32'd7);
    endtask

    task automatic test_back_to_back();
        int           cyc;
        logic [W-1:0] a1, b1, a2;
        a1 = 32'hCAFE_F00D; b1 = 32'h0F0F_0F0F; a2 = 32'h1357_9BDF;
        @(negedge clock);
        sb.push_back(expect_op(4'd0, a1, b1));
        op_valid = 1'b1; op_code = 4'd0; op_a = a1; op_b = b1;
        @(negedge clock);
        sb.push_back(expect_op(4'd12, a2, 32'd0));
        op_code = 4'd12; op_a = a2; op_b = 32'd0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) begin
                checks++;
                if (alu_a !== a1 || alu_instruc !== 13'h0001) begin
                    errors++;
                    $display("FAIL b2b_hold a=%h instruc=%h required %h 0001", alu_a, alu_instruc, a1);
                end
            end
        end
        checks++;
        if (cyc != 3 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first latency=%0d ready=%b required 3 1", cyc, op_ready);
        end
        @(negedge clock);
        op_valid = 1'b0;
        checks++;
        if (alu_instruc !== 13'h1000 || alu_a !== a2) begin
            errors++;
            $display("FAIL b2b_second_accept instruc=%h a=%h required 1000 %h", alu_instruc, alu_a, a2);
        end
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL b2b_second latency=%0d required 3", cyc);
        end
    endtask

    task automatic test_clear_mid();
        @(negedge clock);
        sb.push_back(expect_op(4'd5, 32'd1000, 32'd3));
        op_valid = 1'b1; op_code = 4'd5; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (2) @(negedge clock);
        // Second WAIT cycle: clear discards the DIV.
        clear = 1'b1; op_valid = 1'b1; op_code = 4'd1; op_a = 32'hAAAA_0000; op_b = 32'h0000_5555;
        void'(sb.pop_back());
        exp_hi = '0;
        @(negedge clock);
        checks++;
        if (op_ready !== 1'b1 || alu_instruc !== 0 || alu_a !== 0 || alu_b !== 0 || z_lo !== 0 ||
            z_hi !== 0 || z_carry !== 0 || done !== 0 || illegal !== 0 || div_zero !== 0) begin
            errors++;
            $display("FAIL clear_mid ready=%b instruc=%h a=%h b=%h lo=%h hi=%h c=%b d=%b il=%b dz=%b required 1 and all zero",
                     op_ready, alu_instruc, alu_a, alu_b, z_lo, z_hi, z_carry, done, illegal, div_zero);
        end
        @(negedge clock);
        checks++;
        if (op_ready !== 1'b1 || alu_instruc !== 0) begin
            errors++;
            $display("FAIL clear_dominates ready=%b instruc=%h required 1 0", op_ready, alu_instruc);
        end
        clear = 1'b0; op_valid = 1'b0;
        repeat (MW + 3) @(negedge clock);
        do_op(4'd1, 32'hAAAA_0000, 32'h0000_5555);
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_div_zero();
        test_illegal(4'd14);
        test_illegal(4'd13);
        test_ops();
        test_back_to_back();
        test_clear_mid();
        repeat (3) @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL outstanding_ops left=%0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and results.
REQ-002 Parameter MULDIV_WAIT, default 4, settle cycles for MUL/DIV, legal range 1..15.
REQ-003 clock  input  1  rising-edge clock, sole clock domain.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 op_valid  input  1  operation request.
REQ-006 op_ready  output  1  sequencer idle, request accepted when op_valid && op_ready.
REQ-007 op_code  input  4  select index 0..12: AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
REQ-008 op_a, op_b  input  WIDTH  operands, sampled at acceptance.
REQ-009 alu_instruc  output  13  one-hot ALU select, bit n = op_code n.
REQ-010 alu_a, alu_b  output  WIDTH  latched operands driven to ALU.
REQ-011 alu_result, alu_result_hi  input  WIDTH  ALU low/high result.
REQ-012 alu_carry  input  1  ALU adder carry-out.
REQ-013 z_lo, z_hi  output  WIDTH  result registers.
REQ-014 z_carry  output  1  captured carry.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 illegal  output  1  one-cycle pulse, op_code 13..15 rejected.
REQ-017 div_zero  output  1  one-cycle pulse, DIV with op_b == 0.

Function
REQ-018 FSM states IDLE, EXEC, WAIT, CAPT; op_ready SHALL be 1 only in IDLE.
REQ-019 IDLE: alu_instruc SHALL be 13'b0; on acceptance latch op_a, op_b, op_code; legal code -> EXEC.
REQ-020 Illegal code accepted: stay IDLE, illegal = 1 next cycle, z_lo/z_hi/z_carry unchanged, no done.
REQ-021 EXEC, WAIT, CAPT: alu_instruc SHALL hold the one-hot code; alu_a/alu_b SHALL hold latched operands.
REQ-022 EXEC -> CAPT for all codes except MUL/DIV; MUL and nonzero-divisor DIV: EXEC -> WAIT.
REQ-023 WAIT: down-counter loaded with MULDIV_WAIT at EXEC; WAIT -> CAPT when counter reaches 1, exactly MULDIV_WAIT WAIT cycles.
REQ-024 CAPT edge: z_lo <= alu_result; state -> IDLE; done = 1 for following cycle only.
REQ-025 z_hi <= alu_result_hi on MUL/DIV capture only; all other codes leave z_hi unchanged.
REQ-026 z_carry <= alu_carry on ADD/SUB capture; <= 0 on any other capture.
REQ-027 DIV with op_b == 0: EXEC -> CAPT without WAIT; capture z_lo = all ones, z_hi = latched op_a; div_zero and done pulse together.
REQ-028 Latency accept-edge to done-high: 3 cycles single-cycle ops, 3 + MULDIV_WAIT for MUL/DIV.
REQ-029 done cycle coincides with op_ready = 1; back-to-back acceptance in done cycle SHALL be legal.
REQ-030 op_valid while busy SHALL be ignored; op_a/op_b changes while busy SHALL not affect alu_a/alu_b.
REQ-031 z_lo/z_hi/z_carry SHALL change only on CAPT edge or clear.

Reset
REQ-032 clear high at a clock edge, any state: state -> IDLE, counter 0, alu_instruc/alu_a/alu_b/z_lo/z_hi/z_carry = 0, done/illegal/div_zero = 0, op_ready = 1 next cycle.
REQ-033 clear mid-operation SHALL discard the in-flight op with no done pulse; clear SHALL dominate simultaneous op_valid.

Verification
REQ-034 ADD op_a=0xFFFFFFFF op_b=1 -> alu_instruc=0x0004 in EXEC/CAPT, done 3 cycles after accept, z_lo=0, z_carry=1, z_hi unchanged.
REQ-035 MUL op_a=0x10000 op_b=0x10000, MULDIV_WAIT=4 -> alu_instruc=0x0010 for 6 cycles, done at 7, z_lo=0, z_hi=1, z_carry=0.
REQ-036 DIV op_a=7 op_b=0 -> no WAIT, done and div_zero at cycle 3, z_lo=0xFFFFFFFF, z_hi=7.
REQ-037 op_code=14 -> illegal pulse next cycle, op_ready stays 1, alu_instruc=0, z registers unchanged, no done.
REQ-038 Back-to-back AND then NOT with op_valid held -> second accept in first done cycle, second done 3 cycles later, z_lo = ~op_a.
REQ-039 clear asserted in 2nd WAIT cycle of DIV -> next cycle all outputs 0, op_ready=1, no done; new OR op completes normally.
